truth_table_sweeper: RTL and testbench

- Sequential stimulus-and-check stage that wraps the combinational SOP/POS gate networks.
- Upstream role: drives every input combination onto a, b, c, d.
- Downstream role: samples both implementation outputs (minterm and maxterm forms) and compares each against a parameterised expected truth table.
- Reports pass/fail, a mismatch count and the first failing vector, so both forms can be proven equivalent in hardware without a hand-written $monitor sweep.

---
 rtl/sweep_pkg.sv | 15 +
 rtl/sweep_vector_counter.sv | 44 ++++
 rtl/truth_table_sweeper.sv | 147 ++++++++++++++
 tb/tb_truth_table_sweeper.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// Shared encodings and widths for the truth-table sweeper and its vector counter.
package sweep_pkg;

  localparam int MAX_INPUTS = 4;
  localparam int ERR_W      = 5;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/sweep_vector_counter.sv
// Holds the current stimulus vector and the settle counter that paces sampling.
module sweep_vector_counter
  import sweep_pkg::*;
#(
  parameter int N_INPUTS      = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic                  i_count,
  input  logic                  i_advance,
  output logic [MAX_INPUTS-1:0] o_vec,
  output logic                  o_last_vec,
  output logic                  o_settled
);

  localparam logic [MAX_INPUTS-1:0] LAST_VEC  = MAX_INPUTS'((1 << N_INPUTS) - 1);
  localparam logic [CNT_W-1:0]      SETTLE_TC = CNT_W'(SETTLE_CYCLES - 1);

  logic [MAX_INPUTS-1:0] r_vec;
  logic [CNT_W-1:0]      r_cnt;

  // The last vector wraps to 0 so the stimulus is already back at 0 during DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vec <= '0;
      r_cnt <= '0;
    end else if (i_load) begin
      r_vec <= '0;
      r_cnt <= '0;
    end else if (i_advance) begin
      r_vec <= (r_vec == LAST_VEC) ? '0 : r_vec + MAX_INPUTS'(1);
      r_cnt <= '0;
    end else if (i_count) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_vec      = r_vec;
  assign o_last_vec = (r_vec == LAST_VEC);
  assign o_settled  = (r_cnt == SETTLE_TC);

endmodule

// File: rtl/truth_table_sweeper.sv
// Sweeps every input vector onto a/b/c/d and checks the SOP and POS outputs
// against EXP_TABLE, reporting pass, mismatch count and first failing vector.
//   state  | meaning
//   IDLE   | waiting for start; results held
//   SETTLE | vector driven, waiting SETTLE_CYCLES
//   SAMPLE | compare min_i/max_i against expected bit
//   DONE   | one-cycle done pulse, pass valid
module truth_table_sweeper
  import sweep_pkg::*;
#(
  parameter int          N_INPUTS      = 4,
  parameter int          SETTLE_CYCLES = 1,
  parameter logic [15:0] EXP_TABLE     = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  min_i,
  input  logic                  max_i,
  output logic                  a,
  output logic                  b,
  output logic                  c,
  output logic                  d,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_count,
  output logic                  min_fail,
  output logic                  max_fail,
  output logic [MAX_INPUTS-1:0] first_fail,
  output logic                  first_fail_valid
);

  state_t                r_state;
  state_t                w_next;
  logic                  w_load;
  logic                  w_count;
  logic                  w_advance;
  logic                  w_busy;
  logic                  w_done;
  logic [MAX_INPUTS-1:0] w_vec;
  logic                  w_last_vec;
  logic                  w_settled;
  logic                  w_exp;
  logic                  w_em;
  logic                  w_ex;
  logic                  w_fail;

  logic [ERR_W-1:0]      r_err_count;
  logic                  r_min_fail;
  logic                  r_max_fail;
  logic [MAX_INPUTS-1:0] r_first_fail;
  logic                  r_first_fail_valid;
  logic                  r_pass;

  sweep_vector_counter #(
    .N_INPUTS      (N_INPUTS),
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_vec_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_count    (w_count),
    .i_advance  (w_advance),
    .o_vec      (w_vec),
    .o_last_vec (w_last_vec),
    .o_settled  (w_settled)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_SETTLE;
      S_SETTLE: if (w_settled) w_next = S_SAMPLE;
      S_SAMPLE: w_next = w_last_vec ? S_DONE : S_SETTLE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_load    = 1'b0;
    w_count   = 1'b0;
    w_advance = 1'b0;
    w_busy    = 1'b0;
    w_done    = 1'b0;
    case (r_state)
      S_IDLE:   w_load = start;
      S_SETTLE: begin w_count = 1'b1;   w_busy = 1'b1; end
      S_SAMPLE: begin w_advance = 1'b1; w_busy = 1'b1; end
      S_DONE:   w_done = 1'b1;
      default:  w_done = 1'b0;
    endcase
  end

  assign w_exp  = EXP_TABLE[w_vec];
  assign w_em   = w_advance && (min_i != w_exp);
  assign w_ex   = w_advance && (max_i != w_exp);
  assign w_fail = w_em || w_ex;

  // pass is resolved on the final SAMPLE edge so it is already valid alongside done.
  always_ff @(posedge clk) begin
    if (rst || w_load) begin
      r_err_count        <= '0;
      r_min_fail         <= 1'b0;
      r_max_fail         <= 1'b0;
      r_first_fail       <= '0;
      r_first_fail_valid <= 1'b0;
      r_pass             <= 1'b0;
    end else begin
      if (w_em) r_min_fail <= 1'b1;
      if (w_ex) r_max_fail <= 1'b1;
      if (w_fail) begin
        r_err_count <= r_err_count + ERR_W'(1);
        if (!r_first_fail_valid) begin
          r_first_fail       <= w_vec;
          r_first_fail_valid <= 1'b1;
        end
      end
      if (w_advance && w_last_vec) r_pass <= (r_err_count == '0) && !w_fail;
    end
  end

  generate
    if (N_INPUTS == 4) begin : g_four
      assign {a, b, c, d} = w_vec;
    end else begin : g_three
      assign {a, b, c} = w_vec[2:0];
      assign d         = 1'b0;
    end
  endgenerate

  assign busy             = w_busy;
  assign done             = w_done;
  assign pass             = r_pass;
  assign err_count        = r_err_count;
  assign min_fail         = r_min_fail;
  assign max_fail         = r_max_fail;
  assign first_fail       = r_first_fail;
  assign first_fail_valid = r_first_fail_valid;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Scoreboard bench: two sweepers (3-input/settle 1 and 4-input/settle 2) checked
// against a table-level reference model driven by gate models with injected faults.
module tb_truth_table_sweeper;

  localparam logic [15:0] EXP0 = 16'h0067;  // !A!B + !BC + B!C
  localparam logic [15:0] EXP1 = 16'hF666;  // ab + (c ^ d)

  typedef struct packed {
    logic       pass;
    logic [4:0] err;
    logic       minf;
    logic       maxf;
    logic       ffv;
    logic [3:0] ff;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst_w, start_w, min_w, max_w;
  logic [1:0] a_w, b_w, c_w, d_w, busy_w, done_w, pass_w, minf_w, maxf_w, ffv_w;
  logic [1:0][4:0]  err_w;
  logic [1:0][3:0]  ff_w;
  logic [1:0][15:0] flip_min, flip_max;
  logic [1:0]       tie_max0;
  logic [3:0] vec0, vec1;

  int   n_assert = 0;
  int   n_fail   = 0;
  res_t q0[$];
  res_t q1[$];
  int   cyc[2]   = '{-1, -1};
  int   dones[2] = '{0, 0};
  logic [1:0] busy_d = 2'b00;

  truth_table_sweeper #(.N_INPUTS(3), .SETTLE_CYCLES(1), .EXP_TABLE(EXP0)) u_dut3 (
    .clk(clk), .rst(rst_w[0]), .start(start_w[0]), .min_i(min_w[0]), .max_i(max_w[0]),
    .a(a_w[0]), .b(b_w[0]), .c(c_w[0]), .d(d_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .pass(pass_w[0]), .err_count(err_w[0]), .min_fail(minf_w[0]), .max_fail(maxf_w[0]),
    .first_fail(ff_w[0]), .first_fail_valid(ffv_w[0]));

  truth_table_sweeper #(.N_INPUTS(4), .SETTLE_CYCLES(2), .EXP_TABLE(EXP1)) u_dut4 (
    .clk(clk), .rst(rst_w[1]), .start(start_w[1]), .min_i(min_w[1]), .max_i(max_w[1]),
    .a(a_w[1]), .b(b_w[1]), .c(c_w[1]), .d(d_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .pass(pass_w[1]), .err_count(err_w[1]), .min_fail(minf_w[1]), .max_fail(maxf_w[1]),
    .first_fail(ff_w[1]), .first_fail_valid(ffv_w[1]));

  function automatic int n_in(input int k);
    return (k == 0) ? 3 : 4;
  endfunction

  function automatic int settle(input int k);
    return (k == 0) ? 1 : 2;
  endfunction

  function automatic logic sop(input int k, input logic [3:0] v);
    if (k == 0) return (!v[2] && !v[1]) || (!v[1] && v[0]) || (v[1] && !v[0]);
    return (v[3] && v[2]) || (v[1] ^ v[0]);
  endfunction

  function automatic logic pos(input int k, input logic [3:0] v);
    if (k == 0) return (!v[2] || v[1] || v[0]) && (!v[1] || !v[0]);
    return (v[3] || v[1] || v[0]) && (v[3] || !v[1] || !v[0]) &&
           (v[2] || v[1] || v[0]) && (v[2] || !v[1] || !v[0]);
  endfunction

  assign vec0 = {1'b0, a_w[0], b_w[0], c_w[0]};
  assign vec1 = {a_w[1], b_w[1], c_w[1], d_w[1]};
  assign min_w[0] = sop(0, vec0) ^ flip_min[0][vec0];
  assign max_w[0] = tie_max0[0] ? 1'b0 : (pos(0, vec0) ^ flip_max[0][vec0]);
  assign min_w[1] = sop(1, vec1) ^ flip_min[1][vec1];
  assign max_w[1] = tie_max0[1] ? 1'b0 : (pos(1, vec1) ^ flip_max[1][vec1]);

  // Whole-table reference: walk every vector, compare both forms to the table.
  function automatic res_t model(input int k);
    res_t r;
    logic [15:0] tbl;
    logic e, m, x;
    r   = '0;
    tbl = (k == 0) ? EXP0 : EXP1;
    for (int v = 0; v < (1 << n_in(k)); v++) begin
      e = tbl[v];
      m = sop(k, 4'(v)) ^ flip_min[k][v];
      x = tie_max0[k] ? 1'b0 : (pos(k, 4'(v)) ^ flip_max[k][v]);
      if (m != e) r.minf = 1'b1;
      if (x != e) r.maxf = 1'b1;
      if (m != e || x != e) begin
        if (!r.ffv) begin
          r.ffv = 1'b1;
          r.ff  = 4'(v);
        end
        r.err = r.err + 5'd1;
      end
    end
    r.pass = (r.err == 5'd0);
    return r;
  endfunction

  task automatic check(input int k, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL u%0d %s: got %0d, expected %0d (t=%0t)", k, name, act, exp, $time);
    end
  endtask

  task automatic push(input int k, input res_t r);
    if (k == 0) q0.push_back(r);
    else        q1.push_back(r);
  endtask

  task automatic mon(input int k);
    logic [3:0] v;
    res_t r;
    bit   empty;
    v = (k == 0) ? vec0 : vec1;
    if (busy_w[k] && !busy_d[k])      cyc[k] = 0;
    else if (busy_w[k] || done_w[k])  cyc[k] = cyc[k] + 1;
    else                              cyc[k] = -1;
    if (busy_w[k]) check(k, "vec_order", 32'(v), 32'(cyc[k] / (settle(k) + 1)));
    if (k == 0) check(k, "d_zero", 32'(d_w[0]), 0);
    if (done_w[k]) begin
      check(k, "done_latency", 32'(cyc[k]), 32'((1 << n_in(k)) * (settle(k) + 1)));
      check(k, "vec_in_done", 32'(v), 0);
      empty = 1'b0;
      if (k == 0) begin if (q0.size() == 0) empty = 1'b1; else r = q0.pop_front(); end
      else        begin if (q1.size() == 0) empty = 1'b1; else r = q1.pop_front(); end
      check(k, "expected_done", 32'(empty), 0);
      if (!empty) begin
        check(k, "pass",             32'(pass_w[k]), 32'(r.pass));
        check(k, "err_count",        32'(err_w[k]),  32'(r.err));
        check(k, "min_fail",         32'(minf_w[k]), 32'(r.minf));
        check(k, "max_fail",         32'(maxf_w[k]), 32'(r.maxf));
        check(k, "first_fail_valid", 32'(ffv_w[k]),  32'(r.ffv));
        check(k, "first_fail",       32'(ff_w[k]),   32'(r.ff));
      end
      dones[k] = dones[k] + 1;
    end
    busy_d[k] = busy_w[k];
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic wait_dones(input int k, input int target);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(posedge clk);
      if (dones[k] >= target) got = 1'b1;
    end
    check(k, "done_timeout", 32'(got), 1);
  endtask

  task automatic run_sweep(input int k);
    int d0;
    repeat ($urandom_range(0, 3)) @(negedge clk);
    push(k, model(k));
    d0 = dones[k];
    start_w[k] = 1'b1;
    @(negedge clk);
    start_w[k] = 1'b0;
    wait_dones(k, d0 + 1);
    @(negedge clk);
  endtask

  function automatic logic [31:0] all_outs(input int k);
    return 32'({a_w[k], b_w[k], c_w[k], d_w[k], busy_w[k], done_w[k], pass_w[k],
                minf_w[k], maxf_w[k], ffv_w[k], err_w[k], ff_w[k]});
  endfunction

  initial begin
    int d0;
    rst_w    = 2'b11;
    start_w  = 2'b00;
    flip_min = '0;
    flip_max = '0;
    tie_max0 = 2'b00;
    repeat (3) @(negedge clk);
    rst_w = 2'b00;
    @(negedge clk);
    check(0, "reset_outs", all_outs(0), 0);
    check(1, "reset_outs", all_outs(1), 0);

    // Correct 3-input gate models
    run_sweep(0);
    check(0, "s1_pass", 32'(pass_w[0]), 1);
    check(0, "s1_err", 32'(err_w[0]), 0);
    check(0, "s1_ffv", 32'(ffv_w[0]), 0);

    // POS output stuck at 0
    tie_max0[0] = 1'b1;
    run_sweep(0);
    check(0, "s2_err", 32'(err_w[0]), 5);
    check(0, "s2_fails", 32'({minf_w[0], maxf_w[0]}), 32'b01);
    check(0, "s2_first", 32'({ffv_w[0], ff_w[0]}), 32'h10);
    check(0, "s2_pass", 32'(pass_w[0]), 0);

    // Reset in the middle of a faulty sweep, then a clean sweep
    start_w[0] = 1'b1;
    @(negedge clk);
    start_w[0] = 1'b0;
    for (int i = 0; i < 40 && !(busy_w[0] && vec0 == 4'd5); i++) @(negedge clk);
    check(0, "s5_reached_vec5", 32'(vec0), 5);
    rst_w[0] = 1'b1;
    @(negedge clk);
    check(0, "s5_outs_after_rst", all_outs(0), 0);
    rst_w[0]    = 1'b0;
    tie_max0[0] = 1'b0;
    run_sweep(0);
    check(0, "s5_clean_pass", 32'(pass_w[0]), 1);
    check(0, "s5_clean_err", 32'(err_w[0]), 0);

    // 4-input, SOP wrong only at vector 1011
    flip_min[1] = 16'h0800;
    run_sweep(1);
    check(1, "s3_err", 32'(err_w[1]), 1);
    check(1, "s3_first", 32'({ffv_w[1], ff_w[1]}), 32'h1B);
    check(1, "s3_fails", 32'({minf_w[1], maxf_w[1]}), 32'b10);

    // start held high through a sweep and its DONE
    flip_min[1] = 16'h0001 << $urandom_range(1, 15);
    flip_max[1] = 16'($urandom & $urandom);
    push(1, model(1));
    push(1, model(1));
    d0 = dones[1];
    start_w[1] = 1'b1;
    wait_dones(1, d0 + 1);
    for (int i = 0; i < 10 && !busy_w[1]; i++) @(negedge clk);
    check(1, "s4_rearm_busy", 32'(busy_w[1]), 1);
    check(1, "s4_cleared", 32'({pass_w[1], err_w[1], minf_w[1], maxf_w[1], ffv_w[1]}), 0);
    start_w[1] = 1'b0;
    wait_dones(1, d0 + 2);
    @(negedge clk);
    check(1, "s4_done_count", 32'(dones[1] - d0), 2);

    // Random fault masks on both forms
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 2; k++) begin
        flip_min[k] = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom & $urandom & $urandom);
        flip_max[k] = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom & $urandom & $urandom);
        tie_max0[k] = ($urandom_range(0, 3) == 0);
        run_sweep(k);
      end
    end

    check(0, "queue_drained", 32'(q0.size()), 0);
    check(1, "queue_drained", 32'(q1.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
